control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd0, PC value loaded on reset.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr  input  32  instruction word at pc, combinational ROM read.
REQ-005 SHALL have port status  input  4  datapath flags {V,C,N,Z}, Z = status[0].
REQ-006 SHALL have port pc  output  64  current instruction address.
REQ-007 SHALL have ports DA, SA, SB  output  5 each  destination, A-source and B-source register selects to the datapath.
REQ-008 SHALL have ports W  output  1 (register write), K  output  64 (constant), BS  output  1 (1 = B operand is K).
REQ-009 SHALL have ports FS  output  5 (ALU function), write  output  1 (memory write), selEN  output  1 (1 = ALU result to bus, 0 = memory data).
REQ-010 SHALL have port halted  output  1  high once an unsupported opcode is decoded.

Function
REQ-011 SHALL implement FSM FETCH, EXEC, LOAD_WB, HALT.
REQ-012 FETCH: SHALL latch instr into ir; next state is EXEC.
REQ-013 EXEC: SHALL drive the control word decoded from ir; next state is LOAD_WB for LDUR, HALT for illegal, else FETCH.
REQ-014 LOAD_WB: SHALL repeat the LDUR control word with W=1; next state is FETCH.
REQ-015 Latency SHALL be 2 cycles per instruction, or 3 cycles for LDUR.
REQ-016 pc SHALL increment by 4 on leaving EXEC (non-LDUR) or LOAD_WB, with 64-bit wrap-around.
REQ-017 Outside EXEC/LOAD_WB, outputs SHALL be W=0, write=0, selEN=1, DA=SA=SB=0, K=0, BS=0, FS=0.
REQ-018 FS SHALL encode as AND 00000, ORR 00100, ADD 01000, SUB 01011, EOR 01100, LSL 10000, LSR 10100.
REQ-019 R-type ADD/SUB/AND/ORR/EOR (opcodes 10001011000, 11001011000, 10001010000, 10101010000, 11001010000) SHALL drive DA=ir[4:0], SA=ir[9:5], SB=ir[20:16], BS=0, W=1.
REQ-020 ADDI (ir[31:22]=1001000100) SHALL drive K = zero-extended ir[21:10], BS=1, FS=ADD, W=1.
REQ-021 LSL/LSR (11010011011/11010011010) SHALL drive SA=Rn, K = zero-extended ir[15:10], BS=1, W=1.
REQ-022 LDUR (11111000010) SHALL drive SA=Rn, K = sign-extended ir[20:12], BS=1, FS=ADD, selEN=0, DA=ir[4:0], with W=0 in EXEC and W=1 in LOAD_WB.
REQ-023 STUR (11111000000) SHALL drive SA=Rn, SB=ir[4:0], K = sign-extended ir[20:12], BS=1, FS=ADD, write=1, W=0.
REQ-024 Any other opcode SHALL enter HALT; HALT SHALL be absorbing, with halted=1 and pc frozen.
REQ-025 write and W SHALL never both be 1 in the same cycle.

Reset
REQ-026 Reset assertion SHALL immediately force state=FETCH, pc=RESET_PC, ir=0, halted=0 and all control outputs to the REQ-017 values, including mid-LDUR.
REQ-027 The first FETCH SHALL occur on the first rising clock edge after reset deasserts.

Configuration
REQ-028 With CBZ_EN defined, CBZ (ir[31:24]=10110100) SHALL drive SA=ir[4:0], K=0, BS=1, FS=ORR, W=0; on leaving EXEC, pc SHALL become pc + (sign-extended ir[23:5] << 2) if status[0]=1, else pc+4.
REQ-029 Without CBZ_EN, CBZ SHALL be treated as illegal (REQ-024).

Structure
REQ-030 A shared package SHALL hold the state enum, opcode constants, FS constants and the reset-default control-word constant.
REQ-031 The combinational decoder SHALL be the single sub-module instr_decoder, mapping ir to a control word and an illegal flag.

Verification
REQ-032 Scenario: reset release, instr=ADDI X5,XZR,#24 -> EXEC cycle shows DA=5, SA=31, K=24, BS=1, FS=01000, W=1; pc goes 0->4.
REQ-033 Scenario: ADD X1,X5,X7 then EOR X30,X1,X5 -> DA=1/SA=5/SB=7/FS=01000, then DA=30/FS=01100, with BS=0 and W=1 in each EXEC.
REQ-034 Scenario: STUR X17,[X7,#0] -> write=1, W=0, SA=7, SB=17; next instr LDUR X0,[X7,#0] -> EXEC W=0/selEN=0, LOAD_WB W=1/DA=0; pc advances after 3 cycles.
REQ-035 Scenario: instr=32'hFFFFFFFF -> HALT next cycle, halted=1, pc constant for 10 cycles; reset then returns pc=RESET_PC, halted=0.
REQ-036 Scenario: reset asserted during LOAD_WB -> W drops to 0 immediately with no clock edge; state restarts in FETCH.
REQ-037 Scenario (CBZ_EN): CBZ X3,#-2 with status=4'b0001 at pc=16 -> pc=8; with status=0 -> pc=20.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// control_sequencer_pkg
// Shared definitions for the control sequencer: the FSM state type, the
// opcode constants, the ALU function-select codes and the idle control word.
// The optional CBZ support is selected by the CBZ_EN macro. That macro is
// used in instr_decoder; this package only holds the CBZ opcode constant.
// -----------------------------------------------------------------------------
package control_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_LOAD_WB = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    // 11-bit major opcodes (ir[31:21])
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // Shorter opcodes for the immediate and branch formats
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;   // ir[31:22]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;      // ir[31:24]

    // ALU function select
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01011;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    typedef struct packed {
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        w;
        logic [63:0] k;
        logic        bs;
        logic [4:0]  fs;
        logic        write;
        logic        selen;
    } ctrl_t;

    // Idle control word: nothing written, ALU result selected onto the bus
    localparam ctrl_t CTRL_DEFAULT = '{
        da: 5'd0, sa: 5'd0, sb: 5'd0, w: 1'b0, k: 64'd0,
        bs: 1'b0, fs: 5'd0, write: 1'b0, selen: 1'b1
    };

    // ALU function for the three-register formats
    function automatic logic [4:0] rtype_fs(input logic [10:0] op);
        case (op)
            OP_SUB:  return FS_SUB;
            OP_AND:  return FS_AND;
            OP_ORR:  return FS_ORR;
            OP_EOR:  return FS_EOR;
            default: return FS_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of a latched instruction word into a datapath
// control word.
//   ir      : in   32  latched instruction word
//   ctrl    : out  control word for the EXEC cycle
//   illegal : out  opcode not supported, and the sequencer must halt
//   is_ldur : out  load, which needs a write-back cycle
//   is_cbz  : out  conditional branch; this output is only active when
//                  CBZ_EN is defined, and CBZ decodes as illegal otherwise
// -----------------------------------------------------------------------------
module instr_decoder
    import control_sequencer_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic        is_ldur,
    output logic        is_cbz
);

    logic [10:0] op11;
    logic [63:0] imm9_sext;

    assign op11      = ir[31:21];
    assign imm9_sext = {{55{ir[20]}}, ir[20:12]};

    always_comb begin
        ctrl    = CTRL_DEFAULT;
        illegal = 1'b0;
        is_ldur = 1'b0;
        is_cbz  = 1'b0;
        if (ir[31:22] == OP_ADDI) begin
            ctrl.da = ir[4:0];
            ctrl.sa = ir[9:5];
            ctrl.k  = {52'd0, ir[21:10]};
            ctrl.bs = 1'b1;
            ctrl.fs = FS_ADD;
            ctrl.w  = 1'b1;
        end
`ifdef CBZ_EN
        else if (ir[31:24] == OP_CBZ) begin
            // Pass Rt through the ALU (OR with zero), so that the datapath
            // raises Z for the branch decision.
            ctrl.sa = ir[4:0];
            ctrl.bs = 1'b1;
            ctrl.fs = FS_ORR;
            is_cbz  = 1'b1;
        end
`endif
        else begin
            case (op11)
                OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR: begin
                    ctrl.da = ir[4:0];
                    ctrl.sa = ir[9:5];
                    ctrl.sb = ir[20:16];
                    ctrl.fs = rtype_fs(op11);
                    ctrl.w  = 1'b1;
                end
                OP_LSL, OP_LSR: begin
                    ctrl.da = ir[4:0];
                    ctrl.sa = ir[9:5];
                    ctrl.k  = {58'd0, ir[15:10]};
                    ctrl.bs = 1'b1;
                    ctrl.fs = (op11 == OP_LSL) ? FS_LSL : FS_LSR;
                    ctrl.w  = 1'b1;
                end
                OP_LDUR: begin
                    // The address phase has W=0. The sequencer raises W in
                    // the write-back cycle.
                    ctrl.da    = ir[4:0];
                    ctrl.sa    = ir[9:5];
                    ctrl.k     = imm9_sext;
                    ctrl.bs    = 1'b1;
                    ctrl.fs    = FS_ADD;
                    ctrl.selen = 1'b0;
                    is_ldur    = 1'b1;
                end
                OP_STUR: begin
                    ctrl.sa    = ir[9:5];
                    ctrl.sb    = ir[4:0];
                    ctrl.k     = imm9_sext;
                    ctrl.bs    = 1'b1;
                    ctrl.fs    = FS_ADD;
                    ctrl.write = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Multi-cycle instruction sequencer: FETCH -> EXEC (-> LOAD_WB) -> FETCH.
// An unsupported opcode leads to an absorbing HALT state.
//   clock          : in   rising-edge clock
//   reset          : in   asynchronous, active-low reset
//   instr[31:0]    : in   instruction at pc (combinational ROM read)
//   status[3:0]    : in   datapath flags {V,C,N,Z}
//   pc[63:0]       : out  current instruction address
//   DA/SA/SB[4:0]  : out  register selects
//   W, K[63:0], BS : out  register write, constant, B-operand select
//   FS[4:0]        : out  ALU function
//   write, selEN   : out  memory write, bus source (1 = ALU)
//   halted         : out  in HALT
// Optional feature: define CBZ_EN to support CBZ (otherwise it halts).
// -----------------------------------------------------------------------------
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  status,
    output logic [63:0] pc,
    output logic [4:0]  DA,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic        W,
    output logic [63:0] K,
    output logic        BS,
    output logic [4:0]  FS,
    output logic        write,
    output logic        selEN,
    output logic        halted
);

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    ctrl_t       dec_ctrl, ctrl_out;
    logic        dec_illegal, dec_ldur, dec_cbz;
    logic [63:0] pc_plus4, branch_target;
    logic        unused_status;

    instr_decoder u_decoder (
        .ir      (ir_reg),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .is_ldur (dec_ldur),
        .is_cbz  (dec_cbz)
    );

    assign pc_plus4      = pc_reg + 64'd4;
    // The word offset in ir[23:5] is sign-extended and scaled to bytes.
    assign branch_target = pc_reg + {{43{ir_reg[23]}}, ir_reg[23:5], 2'b00};
    assign unused_status = ^status[3:1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_FETCH;
            pc_reg    <= RESET_PC;
            ir_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        ctrl_out   = CTRL_DEFAULT;
        case (state_reg)
            ST_FETCH: begin
                ir_next    = instr;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_illegal) begin
                    // pc stays on the offending instruction
                    state_next = ST_HALT;
                end else begin
                    ctrl_out = dec_ctrl;
                    if (dec_ldur) begin
                        state_next = ST_LOAD_WB;
                    end else begin
                        state_next = ST_FETCH;
                        pc_next    = (dec_cbz && status[0]) ? branch_target
                                                            : pc_plus4;
                    end
                end
            end
            ST_LOAD_WB: begin
                ctrl_out   = dec_ctrl;
                ctrl_out.w = 1'b1;
                state_next = ST_FETCH;
                pc_next    = pc_plus4;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // The outputs are decoded from the state, so the asynchronous reset
    // reaches them without any clock edge.
    assign pc     = pc_reg;
    assign DA     = ctrl_out.da;
    assign SA     = ctrl_out.sa;
    assign SB     = ctrl_out.sb;
    assign W      = ctrl_out.w;
    assign K      = ctrl_out.k;
    assign BS     = ctrl_out.bs;
    assign FS     = ctrl_out.fs;
    assign write  = ctrl_out.write;
    assign selEN  = ctrl_out.selen;
    assign halted = (state_reg == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// The bench feeds the sequencer from a small instruction ROM indexed by pc.
// An instruction-level reference model gives the expected control word,
// the cycle count and the next pc for each instruction. Directed programs
// run first, then random ones, then halt, reset and mid-load-reset cases.
// Define CBZ_EN to build and check the CBZ feature.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_sequencer;

    localparam logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FFF0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr;
    logic [3:0]  status = 4'd0;
    logic [63:0] pc;
    logic [4:0]  DA, SA, SB, FS;
    logic        W, BS, write, selEN, halted;
    logic [63:0] K;

    logic [31:0] rom [0:63];
    logic [63:0] mpc;
    bit          model_halted;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        bit          illegal;
        bit          ldur;
        bit          cbz;
        logic [4:0]  da, sa, sb, fs;
        logic        w, bs, wr, sel;
        logic [63:0] k;
    } exp_t;

    control_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clock  (clock),
        .reset  (reset),
        .instr  (instr),
        .status (status),
        .pc     (pc),
        .DA     (DA),
        .SA     (SA),
        .SB     (SB),
        .W      (W),
        .K      (K),
        .BS     (BS),
        .FS     (FS),
        .write  (write),
        .selEN  (selEN),
        .halted (halted)
    );

    assign instr = rom[pc[7:2]];

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: what the ISA says each instruction must drive.
    function automatic exp_t model(input logic [31:0] word);
        exp_t        e;
        logic [10:0] op;
        op        = word[31:21];
        e.illegal = 1'b0; e.ldur = 1'b0; e.cbz = 1'b0;
        e.da = 5'd0; e.sa = 5'd0; e.sb = 5'd0; e.fs = 5'd0;
        e.w = 1'b0; e.bs = 1'b0; e.wr = 1'b0; e.sel = 1'b1; e.k = 64'd0;
        if (word[31:22] == 10'b1001000100) begin                 // ADDI
            e.da = word[4:0]; e.sa = word[9:5]; e.k = {52'd0, word[21:10]};
            e.bs = 1'b1; e.fs = 5'b01000; e.w = 1'b1;
        end
`ifdef CBZ_EN
        else if (word[31:24] == 8'b10110100) begin                // CBZ
            e.cbz = 1'b1; e.sa = word[4:0]; e.bs = 1'b1; e.fs = 5'b00100;
        end
`endif
        else begin
            case (op)
                11'b10001011000: begin e.da = word[4:0]; e.sa = word[9:5]; e.sb = word[20:16]; e.w = 1'b1; e.fs = 5'b01000; end
                11'b11001011000: begin e.da = word[4:0]; e.sa = word[9:5]; e.sb = word[20:16]; e.w = 1'b1; e.fs = 5'b01011; end
                11'b10001010000: begin e.da = word[4:0]; e.sa = word[9:5]; e.sb = word[20:16]; e.w = 1'b1; e.fs = 5'b00000; end
                11'b10101010000: begin e.da = word[4:0]; e.sa = word[9:5]; e.sb = word[20:16]; e.w = 1'b1; e.fs = 5'b00100; end
                11'b11001010000: begin e.da = word[4:0]; e.sa = word[9:5]; e.sb = word[20:16]; e.w = 1'b1; e.fs = 5'b01100; end
                11'b11010011011: begin e.da = word[4:0]; e.sa = word[9:5]; e.k = {58'd0, word[15:10]}; e.bs = 1'b1; e.w = 1'b1; e.fs = 5'b10000; end
                11'b11010011010: begin e.da = word[4:0]; e.sa = word[9:5]; e.k = {58'd0, word[15:10]}; e.bs = 1'b1; e.w = 1'b1; e.fs = 5'b10100; end
                11'b11111000010: begin
                    e.ldur = 1'b1; e.da = word[4:0]; e.sa = word[9:5];
                    e.k = {{55{word[20]}}, word[20:12]}; e.bs = 1'b1; e.fs = 5'b01000; e.sel = 1'b0;
                end
                11'b11111000000: begin
                    e.sa = word[9:5]; e.sb = word[4:0];
                    e.k = {{55{word[20]}}, word[20:12]}; e.bs = 1'b1; e.fs = 5'b01000; e.wr = 1'b1;
                end
                default: e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Random legal instruction (CBZ only when the feature is built in).
    function automatic logic [31:0] rand_instr();
        logic [31:0]        r;
        logic signed [18:0] off;
        int                 sel;
        r   = $urandom();
        sel = int'($urandom_range(0, 10));
        off = 19'(int'($urandom_range(0, 16)) - 8);
        case (sel)
            0:  return {11'b10001011000, r[20:0]};
            1:  return {11'b11001011000, r[20:0]};
            2:  return {11'b10001010000, r[20:0]};
            3:  return {11'b10101010000, r[20:0]};
            4:  return {11'b11001010000, r[20:0]};
            5:  return {10'b1001000100, r[21:0]};
            6:  return {11'b11010011011, r[20:0]};
            7:  return {11'b11010011010, r[20:0]};
            8:  return {11'b11111000010, r[20:0]};
            9:  return {11'b11111000000, r[20:0]};
`ifdef CBZ_EN
            default: return {8'b10110100, off, r[4:0]};
`else
            default: return {11'b10001011000, r[20:0]};
`endif
        endcase
    endfunction

    // Runs one instruction. The task starts at a negedge in FETCH and
    // returns at the negedge of the next FETCH, or after ten halted cycles.
    task automatic run_instr(input logic [3:0] st);
        logic [31:0] word;
        logic [63:0] next_pc;
        exp_t        e;
        status = st;
        word   = rom[mpc[7:2]];
        e      = model(word);
        check("fetch_pc", pc, mpc);
        check("fetch_w", 64'(W), 64'd0);
        check("fetch_write", 64'(write), 64'd0);
        check("fetch_selen", 64'(selEN), 64'd1);
        check("fetch_sels", 64'({DA, SA, SB, BS, FS}), 64'd0);
        check("fetch_k", K, 64'd0);
        check("fetch_halted", 64'(halted), 64'd0);
        @(negedge clock);
        if (e.illegal) begin
            check("illegal_exec_w", 64'(W), 64'd0);
            check("illegal_exec_write", 64'(write), 64'd0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                check("halt_flag", 64'(halted), 64'd1);
                check("halt_pc", pc, mpc);
                check("halt_w", 64'(W), 64'd0);
            end
            model_halted = 1'b1;
            $display("txn pc=%h instr=%h -> halted", mpc, word);
            return;
        end
        check("exec_pc", pc, mpc);
        check("exec_da", 64'(DA), 64'(e.da));
        check("exec_sa", 64'(SA), 64'(e.sa));
        check("exec_sb", 64'(SB), 64'(e.sb));
        check("exec_w", 64'(W), 64'(e.w));
        check("exec_k", K, e.k);
        check("exec_bs", 64'(BS), 64'(e.bs));
        check("exec_fs", 64'(FS), 64'(e.fs));
        check("exec_write", 64'(write), 64'(e.wr));
        check("exec_selen", 64'(selEN), 64'(e.sel));
        check("exec_w_write_excl", 64'(W & write), 64'd0);
        if (e.ldur) begin
            @(negedge clock);
            check("wb_pc", pc, mpc);
            check("wb_w", 64'(W), 64'd1);
            check("wb_da", 64'(DA), 64'(e.da));
            check("wb_k", K, e.k);
            check("wb_selen", 64'(selEN), 64'd0);
            check("wb_write", 64'(write), 64'd0);
        end
        if (e.cbz && st[0])
            next_pc = mpc + ({{45{word[23]}}, word[23:5]} << 2);
        else
            next_pc = mpc + 64'd4;
        @(negedge clock);
        $display("txn pc=%h instr=%h status=%b -> next pc=%h", mpc, word, st, next_pc);
        mpc = next_pc;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_pc", pc, RESET_PC);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_w", 64'(W), 64'd0);
        check("rst_selen", 64'(selEN), 64'd1);
        @(negedge clock);
        @(negedge clock);
        reset        = 1'b1;
        mpc          = RESET_PC;
        model_halted = 1'b0;
    endtask

    task automatic load_directed();
        rom[60] = {10'b1001000100, 12'd24, 5'd31, 5'd5};           // ADDI X5,XZR,#24
        rom[61] = {11'b10001011000, 5'd7, 6'd0, 5'd5, 5'd1};       // ADD  X1,X5,X7
        rom[62] = {11'b11001010000, 5'd5, 6'd0, 5'd1, 5'd30};      // EOR  X30,X1,X5
        rom[63] = {11'b11111000000, 9'd0, 2'b00, 5'd7, 5'd17};     // STUR X17,[X7,#0]
        rom[0]  = {11'b11111000010, 9'd0, 2'b00, 5'd7, 5'd0};      // LDUR X0,[X7,#0]
        rom[1]  = {11'b11001011000, 5'd4, 6'd0, 5'd3, 5'd2};       // SUB  X2,X3,X4
        rom[2]  = {11'b11010011011, 5'd0, 6'd3, 5'd5, 5'd6};       // LSL  X6,X5,#3
        rom[3]  = {11'b11010011010, 5'd0, 6'd63, 5'd6, 5'd7};      // LSR  X7,X6,#63
        rom[4]  = {8'b10110100, 19'h7FFFE, 5'd3};                   // CBZ  X3,#-2
        rom[5]  = {11'b10101010000, 5'd2, 6'd0, 5'd1, 5'd8};       // ORR  X8,X1,X2
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = rand_instr();
        load_directed();

        // Directed program; the CBZ at pc=16 is taken (Z=1).
        do_reset();
        for (int i = 0; i < 10 && !model_halted; i++)
            run_instr((i == 8) ? 4'b0001 : 4'b0000);

        // Same program; the CBZ falls through (Z=0).
        do_reset();
        for (int i = 0; i < 10 && !model_halted; i++)
            run_instr(4'b0000);

        // Random programs with random flags
        for (int i = 0; i < 64; i++) rom[i] = rand_instr();
        do_reset();
        for (int i = 0; i < 150 && !model_halted; i++)
            run_instr(4'($urandom_range(0, 15)));

        // Illegal opcode: absorbing halt, then recovery by reset
        for (int i = 0; i < 64; i++) rom[i] = 32'hFFFF_FFFF;
        do_reset();
        run_instr(4'b0000);
        check("halt_seen", 64'(model_halted), 64'd1);
        do_reset();

        // Reset asserted in the middle of LOAD_WB
        for (int i = 0; i < 64; i++) rom[i] = {11'b11111000010, 9'h1FD, 2'b00, 5'd2, 5'd9};
        @(negedge clock);                       // EXEC
        check("mid_exec_w", 64'(W), 64'd0);
        @(negedge clock);                       // LOAD_WB
        check("mid_wb_w", 64'(W), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_w", 64'(W), 64'd0);
        check("mid_rst_selen", 64'(selEN), 64'd1);
        check("mid_rst_da", 64'(DA), 64'd0);
        check("mid_rst_pc", pc, RESET_PC);
        $display("txn reset during LOAD_WB at t=%0t", $time);
        @(negedge clock);
        reset        = 1'b1;
        mpc          = RESET_PC;
        model_halted = 1'b0;
        run_instr(4'b0000);
        run_instr(4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
